// File: rtl/wired_bus_pkg.sv
// Shared types, defaults and helpers for the wired-bus scheduler.
package wired_bus_pkg;

    localparam int unsigned DEF_N_DRV      = 4;
    localparam int unsigned DEF_W          = 8;
    localparam int unsigned DEF_TURNAROUND = 1;
    localparam int unsigned DEF_MAX_HOLD   = 8;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } sched_state_e;

    // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
    function automatic logic [3:0] onehot_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wired_bus_sched_rr_pick.sv
// Rotating-priority encoder: first requester found searching upward from ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk from the farthest offset down so the nearest requester is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % int'(N));
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wired_bus_sched.sv
// Round-robin time-division scheduler for a shared wand/tri bus with turnaround gaps.
// Optional bus checker enabled by defining WIRED_BUS_XCHK_EN.
module wired_bus_sched
    import wired_bus_pkg::*;
#(
    parameter int unsigned N_DRV      = DEF_N_DRV,
    parameter int unsigned W          = DEF_W,
    parameter int unsigned TURNAROUND = DEF_TURNAROUND,
    parameter int unsigned MAX_HOLD   = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DRV-1:0]         req,
    input  logic [N_DRV-1:0]         last,
    output logic [N_DRV-1:0]         gnt,
    output logic [N_DRV-1:0]         oe,
    output logic [$clog2(N_DRV)-1:0] owner,
    output logic                     busy,
    input  logic [W-1:0]             bus_mon,
    output logic                     xerr
);

    localparam int unsigned IW = $clog2(N_DRV);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    localparam logic [N_DRV-1:0] ONE       = {{(N_DRV - 1){1'b0}}, 1'b1};
    localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [1:0]       TURN_LOAD = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

    sched_state_e      state_q, state_d;
    logic [N_DRV-1:0]  gnt_q, gnt_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [1:0]        turn_q, turn_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic              arb;
    logic              own_exit;

    rr_pick #(
        .N  (N_DRV),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        owner = IW'(onehot_idx(16'(gnt_q)));
    end

    assign gnt  = gnt_q;
    assign oe   = gnt_q;
    assign busy = (state_q == OWN);

    // last is only honoured from the current owner, so non-owner pulses fall out here.
    assign own_exit = !req[owner] || last[owner] || (hold_q == HOLD_LAST);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        turn_d   = turn_q;
        rr_ptr_d = rr_ptr_q;
        arb      = 1'b0;

        unique case (state_q)
            IDLE: begin
                arb = 1'b1;
            end
            OWN: begin
                if (own_exit) begin
                    gnt_d  = '0;
                    hold_d = '0;
                    if (TURNAROUND == 0) begin
                        arb = 1'b1;
                    end else begin
                        state_d = TURN;
                        turn_d  = TURN_LOAD;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                // Only the final turnaround cycle samples req.
                if (turn_q == 2'd0) begin
                    arb = 1'b1;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (arb) begin
            if (pick_valid) begin
                state_d  = OWN;
                gnt_d    = ONE << pick_idx;
                hold_d   = '0;
                rr_ptr_d = (pick_idx == IW'(N_DRV - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            hold_q   <= '0;
            turn_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef WIRED_BUS_XCHK_EN
    logic x_seen;
    logic nz_seen;
    logic xerr_q;
    logic xerr_set;

    always_comb begin
        x_seen  = 1'b0;
        nz_seen = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            if (bus_mon[i] === 1'bx) begin
                x_seen = 1'b1;
            end
            if (bus_mon[i] !== 1'bz) begin
                nz_seen = 1'b1;
            end
        end
    end

    // First OWN cycle and first TURN cycle are settling windows for the net.
    always_comb begin
        xerr_set = 1'b0;
        if (state_q == OWN && hold_q != '0 && x_seen) begin
            xerr_set = 1'b1;
        end
        if ((state_q == IDLE || (state_q == TURN && turn_q != TURN_LOAD)) && nz_seen) begin
            xerr_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xerr_q <= 1'b0;
        end else if (xerr_set) begin
            xerr_q <= 1'b1;
        end
    end

    assign xerr = xerr_q;
`else
    logic unused_bus_mon;
    assign unused_bus_mon = ^bus_mon;
    assign xerr           = 1'b0;
`endif

endmodule
